// File: rtl/client_pkt_arbiter_pkg.sv
// Shared types and helpers for the packet-granular client arbiter.
//   arb_state_e : arbiter FSM states (idle / locked to one packet owner)
//   beat_t      : one client beat at the default bundle widths
//   rr_next     : round-robin grant search used by rr_priority_picker
package client_arb_pkg;

  localparam int MAX_CLIENTS = 8;
  localparam int BEAT_DATA_W = 64;
  localparam int BEAT_KEEP_W = BEAT_DATA_W / 8;
  localparam int BEAT_USER_W = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic [BEAT_KEEP_W-1:0] keep;
    logic [BEAT_USER_W-1:0] user;
    logic                   sop;
    logic                   eop;
  } beat_t;

  // Returns the first requester at or after ptr, scanning upward with wrap
  // over n clients. With no request set the pointer itself comes back; the
  // caller qualifies the result with its own any-request flag.
  function automatic int rr_next(input logic [MAX_CLIENTS-1:0] req,
                                 input int ptr, input int n);
    int   grant;
    int   pos;
    logic found;
    grant = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_CLIENTS; i++) begin
      // ptr < n and i < n, so a single subtraction is enough to wrap.
      pos = ptr + i;
      if (pos >= n) pos = pos - n;
      if (i < n && !found && ((req >> pos) & MAX_CLIENTS'(1)) != '0) begin
        grant = pos;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/client_pkt_arbiter_picker.sv
// rr_priority_picker: combinational round-robin picker.
//   req_i   : request vector, one bit per client
//   ptr_i   : index that has highest priority this cycle
//   valid_o : at least one request present
//   idx_o   : first requesting index at or after ptr_i (with wrap)
module rr_priority_picker
  import client_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);

  assign valid_o = |req_i;
  assign idx_o   = W'(rr_next(MAX_CLIENTS'(req_i), int'(ptr_i), N));

endmodule

// File: rtl/client_pkt_arbiter.sv
// client_pkt_arbiter: merges N client beat streams into one registered
// stream, granting whole packets round-robin and never interleaving them.
//   clk / rst_n            : clock, asynchronous active-low reset
//   in_data/keep/user      : per-client beat payload
//   in_valid/sop/eop       : per-client beat qualifiers
//   in_ready               : per-client accept (combinational)
//   out_*                  : registered merged beat, out_src = producing client
//   out_ready              : downstream accept
//   err_orphan             : per-client pulse when a stray non-sop beat is dropped
//   err_nested             : pulse when the lock owner sends sop mid-packet
//   dbg_state_o/dbg_rr_ptr_o : FSM state (1 = locked) and round-robin pointer
// Handshake: a beat transfers in any cycle where valid and ready are both 1;
// a producer holds valid and payload stable until that cycle, and ready may
// depend on valid only through the orphan/grant rules below.
module client_pkt_arbiter
  import client_arb_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int IF_W      = 64,
  parameter int TUSER_W   = 16,
  parameter int SRC_W     = $clog2(N_CLIENTS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_CLIENTS-1:0][IF_W-1:0]       in_data,
  input  logic [N_CLIENTS-1:0][IF_W/8-1:0]     in_keep,
  input  logic [N_CLIENTS-1:0][TUSER_W-1:0]    in_user,
  input  logic [N_CLIENTS-1:0]                 in_valid,
  input  logic [N_CLIENTS-1:0]                 in_sop,
  input  logic [N_CLIENTS-1:0]                 in_eop,
  output logic [N_CLIENTS-1:0]                 in_ready,
  output logic [IF_W-1:0]                      out_data,
  output logic [IF_W/8-1:0]                    out_keep,
  output logic [TUSER_W-1:0]                   out_user,
  output logic                                 out_valid,
  output logic                                 out_sop,
  output logic                                 out_eop,
  output logic [SRC_W-1:0]                     out_src,
  input  logic                                 out_ready,
  output logic [N_CLIENTS-1:0]                 err_orphan,
  output logic                                 err_nested,
  output logic                                 dbg_state_o,
  output logic [SRC_W-1:0]                     dbg_rr_ptr_o
);

  arb_state_e           state_q;
  logic [SRC_W-1:0]     owner_q;
  logic [SRC_W-1:0]     rr_ptr_q;
  logic [SRC_W-1:0]     rr_ptr_d;
  logic                 out_valid_q;
  logic [IF_W-1:0]      out_data_q;
  logic [IF_W/8-1:0]    out_keep_q;
  logic [TUSER_W-1:0]   out_user_q;
  logic                 out_sop_q;
  logic                 out_eop_q;
  logic [SRC_W-1:0]     out_src_q;

  logic                 slot_free;
  logic                 is_lock;
  logic                 pick_valid;
  logic [SRC_W-1:0]     pick_idx;
  logic [SRC_W-1:0]     sel_idx;
  logic                 take;
  logic [N_CLIENTS-1:0] owner_hot;
  logic [N_CLIENTS-1:0] grant_hot;
  logic [N_CLIENTS-1:0] orphan;

  assign slot_free = !out_valid_q || out_ready;
  assign is_lock   = (state_q == ARB_LOCK);

  // Only sop beats compete for a new grant.
  rr_priority_picker #(
    .N (N_CLIENTS),
    .W (SRC_W)
  ) u_picker (
    .req_i   (in_valid & in_sop),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign sel_idx  = is_lock ? owner_q : pick_idx;
  assign take     = slot_free && (is_lock ? in_valid[owner_q] : pick_valid);
  assign rr_ptr_d = (sel_idx == SRC_W'(N_CLIENTS - 1)) ? '0 : sel_idx + SRC_W'(1);

  always_comb begin
    owner_hot = '0;
    grant_hot = '0;
    for (int c = 0; c < N_CLIENTS; c++) begin
      if (is_lock && owner_q == SRC_W'(c)) owner_hot[c] = 1'b1;
      if (!is_lock && pick_valid && pick_idx == SRC_W'(c)) grant_hot[c] = 1'b1;
    end
  end

  // A non-sop beat from anyone but the lock owner can never be part of a
  // granted packet, so it is swallowed at once regardless of the output slot.
  assign orphan     = in_valid & ~in_sop & ~owner_hot;
  assign in_ready   = orphan | ({N_CLIENTS{slot_free}} & (owner_hot | grant_hot));
  assign err_orphan = orphan;
  assign err_nested = take && is_lock && in_sop[owner_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_user_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_src_q   <= '0;
    end else begin
      // The output register only changes when its current beat has left.
      if (slot_free) begin
        out_valid_q <= take;
        if (take) begin
          out_data_q <= in_data[sel_idx];
          out_keep_q <= in_keep[sel_idx];
          out_user_q <= in_user[sel_idx];
          out_sop_q  <= in_sop[sel_idx];
          out_eop_q  <= in_eop[sel_idx];
          out_src_q  <= sel_idx;
        end
      end
      if (take) begin
        if (in_eop[sel_idx]) begin
          state_q  <= ARB_IDLE;
          rr_ptr_q <= rr_ptr_d;
        end else if (!is_lock) begin
          state_q <= ARB_LOCK;
          owner_q <= sel_idx;
        end
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_keep     = out_keep_q;
  assign out_user     = out_user_q;
  assign out_sop      = out_sop_q;
  assign out_eop      = out_eop_q;
  assign out_src      = out_src_q;
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_client_pkt_arbiter.sv
// Randomized bench for client_pkt_arbiter: per-client beat queues feed the
// DUT, a packet-level reference model predicts accepts and pushes expected
// output beats into exp_q, and a monitor pops them on every output handshake.
module tb_client_pkt_arbiter;
  import client_arb_pkg::*;

  localparam int N    = 4;
  localparam int IF_W = BEAT_DATA_W;
  localparam int KW   = BEAT_KEEP_W;
  localparam int TU   = BEAT_USER_W;
  localparam int SW   = 2;
  localparam int OW   = SW + $bits(beat_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0][IF_W-1:0] in_data;
  logic [N-1:0][KW-1:0]   in_keep;
  logic [N-1:0][TU-1:0]   in_user;
  logic [N-1:0]           in_valid, in_sop, in_eop, in_ready, err_orphan;
  logic [IF_W-1:0]        out_data;
  logic [KW-1:0]          out_keep;
  logic [TU-1:0]          out_user;
  logic                   out_valid, out_sop, out_eop, out_ready, err_nested;
  logic [SW-1:0]          out_src, dbg_rr_ptr;
  logic                   dbg_state;

  client_pkt_arbiter #(
    .N_CLIENTS (N), .IF_W (IF_W), .TUSER_W (TU), .SRC_W (SW)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .in_data (in_data), .in_keep (in_keep), .in_user (in_user),
    .in_valid (in_valid), .in_sop (in_sop), .in_eop (in_eop),
    .in_ready (in_ready),
    .out_data (out_data), .out_keep (out_keep), .out_user (out_user),
    .out_valid (out_valid), .out_sop (out_sop), .out_eop (out_eop),
    .out_src (out_src), .out_ready (out_ready),
    .err_orphan (err_orphan), .err_nested (err_nested),
    .dbg_state_o (dbg_state), .dbg_rr_ptr_o (dbg_rr_ptr)
  );

  // ---------------- bench state ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  int orph_seen = 0;
  int valid_pct = 100;
  int ready_pct = 100;

  beat_t        cq[N][$];       // beats waiting per client
  logic [N-1:0] pres = '0;      // client currently presenting its head beat
  logic [OW-1:0] exp_q[$];      // expected {src, beat} on the output

  // Reference model: packet ownership and round-robin pointer.
  bit m_lock = 1'b0;
  int m_owner = 0;
  int m_rr = 0;
  bit m_ovalid = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_pkt(input int c, input int len, input int nest_at, input bit orphan_first);
    beat_t b;
    if (orphan_first) begin
      b = '{data: {$urandom, $urandom}, keep: KW'($urandom), user: TU'($urandom),
            sop: 1'b0, eop: 1'($urandom)};
      cq[c].push_back(b);
    end
    for (int i = 0; i < len; i++) begin
      b = '{data: {$urandom, $urandom}, keep: KW'($urandom), user: TU'($urandom),
            sop: (i == 0) || (i == nest_at), eop: (i == len - 1)};
      cq[c].push_back(b);
    end
  endtask

  task automatic add_orphan(input int c);
    beat_t b;
    b = '{data: {$urandom, $urandom}, keep: KW'($urandom), user: TU'($urandom),
          sop: 1'b0, eop: 1'b0};
    cq[c].push_back(b);
  endtask

  function automatic bit queues_empty();
    for (int c = 0; c < N; c++) if (cq[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Predict this cycle's handshakes from the packet rules, compare the
  // combinational outputs, then advance the model to the next cycle.
  task automatic model_step();
    logic [N-1:0] e_rdy, e_orph;
    logic         e_nest, slot;
    int           acc;
    beat_t        b;
    slot   = !m_ovalid || out_ready;
    e_rdy  = '0;
    e_orph = '0;
    e_nest = 1'b0;
    acc    = -1;
    for (int c = 0; c < N; c++)
      if (pres[c] && !cq[c][0].sop && !(m_lock && m_owner == c)) e_orph[c] = 1'b1;
    if (slot) begin
      if (m_lock) begin
        e_rdy[m_owner] = 1'b1;
        if (pres[m_owner]) acc = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          int c = (m_rr + k) % N;
          if (acc < 0 && pres[c] && cq[c][0].sop) acc = c;
        end
        if (acc >= 0) e_rdy[acc] = 1'b1;
      end
    end
    e_rdy = e_rdy | e_orph;
    if (m_lock && acc >= 0 && cq[acc][0].sop) e_nest = 1'b1;

    chk("in_ready", in_ready, e_rdy);
    chk("err_orphan", err_orphan, e_orph);
    chk("err_nested", err_nested, e_nest);
    chk("out_valid", out_valid, m_ovalid);
    chk("rr_ptr", dbg_rr_ptr, m_rr);
    chk("lock_state", dbg_state, m_lock);
    orph_seen += $countones(err_orphan);

    if (slot) m_ovalid = (acc >= 0);
    if (acc >= 0) begin
      b = cq[acc].pop_front();
      pres[acc] = 1'b0;
      exp_q.push_back({SW'(acc), b});
      if (b.eop) begin
        m_lock = 1'b0;
        m_rr   = (acc + 1) % N;
      end else begin
        m_lock  = 1'b1;
        m_owner = acc;
      end
    end
    for (int c = 0; c < N; c++)
      if (e_orph[c]) begin
        void'(cq[c].pop_front());
        pres[c] = 1'b0;
      end
  endtask

  // One clock cycle: drive inputs just after the edge, check, wait for next edge.
  task automatic tick();
    for (int c = 0; c < N; c++) begin
      if (!pres[c] && cq[c].size() > 0 && $urandom_range(1, 100) <= valid_pct) pres[c] = 1'b1;
      in_valid[c] = pres[c];
      if (pres[c]) begin
        in_data[c] = cq[c][0].data;
        in_keep[c] = cq[c][0].keep;
        in_user[c] = cq[c][0].user;
        in_sop[c]  = cq[c][0].sop;
        in_eop[c]  = cq[c][0].eop;
      end else begin
        in_data[c] = {$urandom, $urandom};
        in_keep[c] = KW'($urandom);
        in_user[c] = TU'($urandom);
        in_sop[c]  = 1'($urandom);
        in_eop[c]  = 1'($urandom);
      end
    end
    out_ready = ($urandom_range(1, 100) <= ready_pct);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    valid_pct = 100;
    ready_pct = 100;
    while ((!queues_empty() || exp_q.size() != 0) && guard < 300) begin
      tick();
      guard++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  bit            prev_stall = 1'b0;
  logic [OW-1:0] prev_out;
  logic [OW-1:0] cur;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      cur = {out_src, out_data, out_keep, out_user, out_sop, out_eop};
      if (prev_stall) chk("stall_hold", cur, prev_out);
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL out_beat: got %0h expected none (queue empty) at %0t", cur, $time);
        end else begin
          chk("out_beat", cur, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_keep   = '0;
    in_user   = '0;
    in_valid  = '0;
    in_sop    = '0;
    in_eop    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_meta", {out_keep, out_user, out_sop, out_eop, out_src}, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_err", {err_orphan, err_nested}, 0);
    chk("rst_rr_ptr", dbg_rr_ptr, 0);
    rst_n = 1'b1;

    // Four simultaneous 3-beat packets: 12 beats, order 0..3, no gaps.
    for (int c = 0; c < N; c++) add_pkt(c, 3, -1, 1'b0);
    n0 = n_out;
    repeat (13) tick();
    chk("t1_beats_in_13_cycles", n_out - n0, 12);
    drain();

    // Client 3 single-beat packets against client 0: grants alternate.
    for (int i = 0; i < 3; i++) begin
      add_pkt(3, 1, -1, 1'b0);
      add_pkt(0, 1, -1, 1'b0);
    end
    drain();

    // Client 2 four beats, client 1 raises sop one cycle later.
    add_pkt(2, 4, -1, 1'b0);
    tick();
    add_pkt(1, 2, -1, 1'b0);
    drain();

    // Orphan from client 1 in idle.
    add_orphan(1);
    tick();
    drain();

    // Downstream stall for five cycles in the middle of a packet.
    add_pkt(0, 4, 2, 1'b0);
    tick();
    tick();
    ready_pct = 0;
    repeat (5) tick();
    drain();

    // Reset during beat 2 of 4; the remaining beats become orphans.
    add_pkt(2, 4, -1, 1'b0);
    tick();
    rst_n    = 1'b0;
    in_valid = '0;
    pres     = '0;
    void'(cq[2].pop_front());
    exp_q.delete();
    m_lock   = 1'b0;
    m_rr     = 0;
    m_ovalid = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_rr_ptr", dbg_rr_ptr, 0);
    chk("midrst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    orph_seen = 0;
    repeat (3) tick();
    chk("rst_orphan_pulses", orph_seen, 2);
    drain();

    // Randomized traffic with random valid and downstream back-pressure.
    valid_pct = 60;
    ready_pct = 70;
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < N; c++)
        if (cq[c].size() == 0 && $urandom_range(0, 3) == 0) begin
          int len = $urandom_range(1, 4);
          int nest = (len >= 2 && $urandom_range(0, 9) == 0) ? $urandom_range(1, len - 1) : -1;
          add_pkt(c, len, nest, $urandom_range(0, 9) == 0);
        end
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
